// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between instruction fetch and load/store, one grant per cycle.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise DATA always wins.
module sram_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

    owner_e owner_q, owner_d;
    logic   vld_q, vld_d;
    logic   cancel_q, cancel_d;
    logic   gnt_inst, gnt_data;

`ifdef ARB_ROUND_ROBIN_EN
    // fav_data_q = 1 means DATA wins the next conflict; it flips only on conflicts.
    logic fav_data_q, fav_data_d;

    always_comb begin
        gnt_data   = !reset && data_req && (!inst_req || fav_data_q);
        gnt_inst   = !reset && inst_req && (!data_req || !fav_data_q);
        fav_data_d = fav_data_q;
        if (!reset && inst_req && data_req)
            fav_data_d = !fav_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) fav_data_q <= 1'b1;
        else       fav_data_q <= fav_data_d;
    end
`else
    always_comb begin
        gnt_data = !reset && data_req;
        gnt_inst = !reset && inst_req && !data_req;
    end
`endif

    always_comb begin
        sram_en      = 1'b0;
        sram_wen     = 4'h0;
        sram_addr    = 32'h0;
        sram_wdata   = 32'h0;
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        if (gnt_data) begin
            sram_en    = 1'b1;
            sram_wen   = data_wr ? data_wstrb : 4'h0;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (gnt_inst) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
        end
    end

    // Response bookkeeping; a cancel seen in the grant cycle is remembered for the response cycle.
    always_comb begin
        vld_d    = gnt_inst || gnt_data;
        owner_d  = gnt_data ? OWN_DATA : OWN_INST;
        cancel_d = gnt_inst && inst_cancel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= 1'b0;
            owner_q  <= OWN_INST;
            cancel_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            owner_q  <= owner_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        inst_data_ok = !reset && vld_q && (owner_q == OWN_INST) && !cancel_q && !inst_cancel;
        data_data_ok = !reset && vld_q && (owner_q == OWN_DATA);
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios followed by random traffic.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_cancel = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;

    sram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_inst;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    // Reference state: who wins the next conflict, and what was granted last cycle.
    bit   fav_data = 1'b1;
    int   prev_g = 0;        // 0 none, 1 inst, 2 data
    bit   prev_cancel = 1'b0;
    int   last_g = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d: got 0x%08h, required 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit ireq, input logic [31:0] iaddr, input bit icancel,
                         input bit dreq, input bit dwr, input logic [3:0] wstrb,
                         input logic [31:0] daddr, input logic [31:0] wdata);
        int g;
        @(negedge clk);
        cyc++;
        reset = rst; inst_req = ireq; inst_addr = iaddr; inst_cancel = icancel;
        data_req = dreq; data_wr = dwr; data_wstrb = wstrb; data_addr = daddr; data_wdata = wdata;
        sram_rdata = $urandom;
        // Response owed this cycle by last cycle's grant, unless reset or cancel kills it.
        if (!rst && prev_g == 1 && !prev_cancel && !icancel)
            sb.push_back('{cyc, 1'b1, sram_rdata});
        if (!rst && prev_g == 2)
            sb.push_back('{cyc, 1'b0, sram_rdata});
        g = 0;
        if (rst) begin
            fav_data = 1'b1;
        end else if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = fav_data ? 2 : 1;
            fav_data = (g == 1);
`else
            g = 2;
`endif
        end else if (dreq) g = 2;
        else if (ireq) g = 1;
        prev_g = g; prev_cancel = icancel; last_g = g;
        #1;
        check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, g == 1});
        check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, g == 2});
        check("sram_en", {31'b0, sram_en}, {31'b0, g != 0});
        check("sram_wen", {28'b0, sram_wen}, {28'b0, (g == 2 && dwr) ? wstrb : 4'h0});
        check("sram_addr", sram_addr, g == 1 ? iaddr : (g == 2 ? daddr : 32'h0));
        check("sram_wdata", sram_wdata, g == 2 ? wdata : 32'h0);
    endtask

    task automatic idle(input bit rst);
        cycle(rst, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // Monitor: every response the DUT shows must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (inst_data_ok || data_data_ok) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_resp cyc=%0d: got inst_ok=%b data_ok=%b, required none",
                             cyc, inst_data_ok, data_data_ok);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", {30'b0, inst_data_ok, data_data_ok},
                          e.is_inst ? 32'h2 : 32'h1);
                    check("resp_rdata", e.is_inst ? inst_rdata : data_rdata, e.rdata);
                end
            end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                compared++; mismatched++;
                $display("FAIL missing_resp cyc=%0d: got no data_ok, required %s data_ok",
                         cyc, e.is_inst ? "inst" : "data");
            end
        end
    end

    initial begin
        bit ir, dr, dw, ic, rs;
        logic [31:0] ia, da, wd;
        logic [3:0] ws;

        // Reset with everything asserted: nothing may be granted.
        cycle(1, 1, 32'h100, 1, 1, 1, 4'hF, 32'h200, 32'h1234);
        idle(1);
        idle(0);
        // Single fetch, then store.
        cycle(0, 1, 32'h1C000000, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        idle(0);
        cycle(0, 0, 32'h0, 0, 1, 1, 4'b0011, 32'h1C000100, 32'hDEADBEEF);
        idle(0);
        // Conflict held for four cycles.
        repeat (4) cycle(0, 1, 32'h1C000040, 0, 1, 0, 4'h0, 32'h1C000200, 32'h0);
        idle(0);
        // Back-to-back fetches.
        cycle(0, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(0, 1, 32'h4, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(0, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        idle(0);
        // Cancel in response cycle while a data read is granted.
        cycle(0, 1, 32'h1C000010, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(0, 0, 32'h0, 1, 1, 0, 4'h0, 32'h1C000300, 32'h0);
        idle(0);
        // Cancel in grant cycle.
        cycle(0, 1, 32'h1C000014, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        idle(0);
        // Reset right after a grant, then a conflict.
        cycle(0, 0, 32'h0, 0, 1, 1, 4'hF, 32'h1C000400, 32'hCAFEF00D);
        idle(1);
        cycle(0, 1, 32'h1C000020, 0, 1, 0, 4'h0, 32'h1C000500, 32'h0);
        check("post_reset_conflict_winner", {31'b0, data_addr_ok}, 32'h1);
        idle(0);

        // Random traffic; a requester that was not granted holds its request.
        ir = 0; dr = 0; dw = 0; ia = 0; da = 0; wd = 0; ws = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(ir && last_g != 1)) begin
                ir = ($urandom_range(0, 99) < 60);
                ia = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            if (!(dr && last_g != 2)) begin
                dr = ($urandom_range(0, 99) < 60);
                dw = $urandom_range(0, 1);
                ws = $urandom_range(0, 15);
                da = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                wd = $urandom;
            end
            ic = ($urandom_range(0, 99) < 10);
            rs = ($urandom_range(0, 99) < 2);
            cycle(rs, ir, ia, ic, dr, dw, ws, da, wd);
        end
        idle(0);
        idle(0);
        @(negedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state updates on its rising edge
  reset  in  1  synchronous, active-high reset
  inst_req  in  1  fetch request (always a read)
  inst_addr  in  32  fetch address
  inst_cancel  in  1  discard outstanding fetch response (branch taken)
  inst_addr_ok  out  1  fetch request accepted this cycle
  inst_data_ok  out  1  fetch response valid this cycle
  inst_rdata  out  32  fetch response data
  data_req  in  1  load/store request
  data_wr  in  1  1 = write, 0 = read
  data_wstrb  in  4  byte write strobes
  data_addr  in  32  load/store address
  data_wdata  in  32  store data
  data_addr_ok  out  1  data request accepted this cycle
  data_data_ok  out  1  data response valid this cycle
  data_rdata  out  32  load response data
  sram_en  out  1  shared SRAM enable
  sram_wen  out  4  shared SRAM byte write enables
  sram_addr  out  32  shared SRAM address
  sram_wdata  out  32  shared SRAM write data
  sram_rdata  in  32  shared SRAM read data, valid one cycle after sram_en

Function
REQ-002 SHALL grant at most one requester per cycle; the grant is combinational from the current req inputs and the arbiter state.
REQ-003 SHALL assert addr_ok to the granted requester in the same cycle as its req, and SHALL drive sram_en = 1 with that requester's address, wdata and strobes.
REQ-004 SHALL drive sram_wen = 4'h0 for fetch grants and for data reads; for data writes sram_wen = data_wstrb.
REQ-005 SHALL drive sram_en = 0, sram_wen = 0, sram_addr = 0 and sram_wdata = 0 in cycles with no grant.
REQ-006 SHALL record the granted requester in a 2-state owner register (INST, DATA) plus a valid bit; the response is due exactly one cycle after the grant.
REQ-007 SHALL assert data_ok for exactly one cycle, in the cycle after the grant, to the recorded owner; writes also receive data_ok.
REQ-008 SHALL pass sram_rdata through to inst_rdata and data_rdata unchanged; the rdata outputs are meaningful only while the matching data_ok is asserted.
REQ-009 SHALL suppress inst_data_ok if inst_cancel is high in the grant cycle or in the response cycle.
REQ-010 SHALL accept a new grant in the same cycle as a response; the port sustains one request per cycle.
REQ-011 SHALL, when only one requester is asserting req, grant it regardless of priority state.
REQ-012 SHALL, on simultaneous inst_req and data_req, grant according to REQ-016/REQ-017; the loser sees addr_ok = 0 and must hold its request.

Reset
REQ-013 SHALL, while reset is high, force all addr_ok, data_ok, sram_en and sram_wen outputs to 0, clear the response-valid bit, and set the round-robin pointer to favour DATA.
REQ-014 SHALL, when reset asserts with a response pending, drop that response; no data_ok is issued in the cycle after reset deasserts.
REQ-015 SHALL ignore inst_cancel while reset is high.

Configuration
REQ-016 With ARB_ROUND_ROBIN_EN defined, SHALL resolve conflicts round-robin:
  - the requester that lost the last conflict wins the next conflict;
  - the pointer updates only on conflict cycles;
  - neither requester waits more than one conflict cycle.
REQ-017 Without ARB_ROUND_ROBIN_EN, SHALL give fixed priority to DATA on every conflict; no pointer register is present.

Verification
REQ-018 Single fetch: inst_req=1, inst_addr=0x1C000000, data_req=0 -> same cycle inst_addr_ok=1, sram_en=1, sram_addr=0x1C000000, sram_wen=0; next cycle inst_data_ok=1, inst_rdata=sram_rdata.
REQ-019 Store: data_req=1, data_wr=1, data_wstrb=4'b0011, data_addr=0x1C000100, data_wdata=0xDEADBEEF -> sram_wen=4'b0011 and sram_wdata=0xDEADBEEF that cycle; data_data_ok=1 next cycle; inst_data_ok stays 0.
REQ-020 Conflict over 4 cycles, both req held high:
  - fixed build: DATA,DATA,DATA,DATA granted;
  - ARB_ROUND_ROBIN_EN build: DATA,INST,DATA,INST granted.
REQ-021 Back-to-back: fetches to 0x0, 0x4, 0x8 on consecutive cycles -> three addr_ok pulses, then three inst_data_ok pulses each one cycle later, with no bubbles.
REQ-022 Cancel: grant fetch 0x1C000010, then pulse inst_cancel=1 in the response cycle -> inst_data_ok=0; a data request granted in that same cycle still completes normally.
REQ-023 Reset mid-operation: assert reset in the cycle after a grant -> no data_ok in that cycle or after release; first post-reset conflict grants DATA.
